filter_frame_ctrl: RTL and testbench
====================================

Name: filter_frame_ctrl

Overview:
- Frame sequencer for the 3x3 blur/Sobel filter chain.
- Accepts a raster pixel stream and tracks column/row position.
- Issues the window-valid strobe only when a full 3x3 neighbourhood exists, and latches per-frame filter configuration at start of frame.
- Delays frame/line markers so they align with filtered results; drains the pipeline and signals frame completion.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- PIPE_LAT, 2, cycles from win_valid to filtered result valid (>=1)
- COL_W, 10, column counter width (2^COL_W >= IMG_WIDTH)
- ROW_W, 9, row counter width (2^ROW_W >= IMG_HEIGHT)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  input pixel present this cycle
- pix_sof  in  1  qualifies first pixel of a frame (row 0, col 0)
- pix_ready  out  1  controller accepts pixel (accept = pix_valid & pix_ready)
- cfg_blur_en  in  1  blur enable request, sampled at SOF
- cfg_sobel_en  in  1  Sobel enable request, sampled at SOF
- blur_en  out  1  latched blur enable for current frame
- sobel_en  out  1  latched Sobel enable for current frame
- win_valid  out  1  window complete; drives the filter window_valid
- col  out  COL_W  column of the last accepted pixel
- row  out  ROW_W  row of the last accepted pixel
- res_sof  out  1  first filtered result of frame, aligned with result valid
- res_eol  out  1  last filtered result of a line, aligned with result valid
- frame_done  out  1  one-cycle pulse after the last result leaves the pipeline
- err_sof  out  1  one-cycle pulse: SOF received mid-frame
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; col=0, row=0; blur_en=0, sobel_en=0; all pulse outputs 0; delay lines cleared. Reset mid-frame aborts immediately with no frame_done.
- States: IDLE, ACTIVE, DRAIN, DONE.
- IDLE: pix_ready=1.
  - Accepted pixel without pix_sof is discarded; counters unchanged.
  - Accept with pix_sof: latch cfg_* into blur_en/sobel_en, col=0, row=0, go to ACTIVE.
- ACTIVE: pix_ready=1.
  - Each accept advances col; on col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - Accept with pix_sof: err_sof pulses next cycle, cfg is re-latched, counters restart at (0,0), and the delay lines are flushed. Results already in flight are dropped.
  - Cycles with pix_valid=0 hold all counters; no strobes are issued.
- win_valid: registered, 1 cycle after the accept of the pixel at (r,c) with r>=2 and c>=2. That window is centred at (r-1,c-1).
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses per frame.
- Marker delay: a PIPE_LAT-deep shift register carries {win_valid, first-window, last-column}.
  - res_sof is set on the first window of the frame (r=2, c=2).
  - res_eol is set on windows with c=IMG_WIDTH-1.
  - Both appear exactly PIPE_LAT cycles after the matching win_valid.
- After the accept of (IMG_HEIGHT-1, IMG_WIDTH-1): go to DRAIN with pix_ready=0.
- DRAIN: counts PIPE_LAT cycles, then enters DONE.
- DONE: frame_done=1 for one cycle, then IDLE. Back-to-back SOF is accepted the following cycle.
- blur_en/sobel_en are stable for the whole frame, including DRAIN. Changes to cfg_* mid-frame are ignored.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, PIPE_LAT=2; SOF plus 12 continuous pixels -> win_valid high 1 cycle after the accepts of (2,2) and (2,3) only (2 pulses); res_sof with the first result, res_eol with the second; frame_done 3 cycles after the second win_valid; pix_ready=0 for 2 cycles during DRAIN.
- Same frame with pix_valid toggled 1/0 every cycle -> same 2 win_valid pulses, each 1 cycle after its accept; counters hold on idle cycles.
- In IDLE, 5 pixels without SOF, then a valid frame -> first 5 ignored; output identical to the first scenario.
- SOF injected at pixel 7 of a frame -> err_sof pulse; counters restart at (0,0); no res_* from the aborted frame; the new frame completes normally.
- cfg_blur_en=1 at SOF, toggled to 0 mid-frame -> blur_en stays 1 until frame_done; the next frame latches 0.
- rst_n asserted during DRAIN -> all outputs 0 immediately; no frame_done; state IDLE after release.

Source files
------------

// File: rtl/filter_frame_ctrl_if.sv
// Pixel-stream, configuration and result-marker signals of the 3x3 filter frame controller.
// The slave side belongs to the controller; the master side drives pixels and config.
interface filter_frame_ctrl_if #(
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 9
) ();
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  logic             cfg_blur_en;
  logic             cfg_sobel_en;
  logic             blur_en;
  logic             sobel_en;
  logic             win_valid;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             res_sof;
  logic             res_eol;
  logic             frame_done;
  logic             err_sof;
  logic             busy;

  modport master (
    output pix_valid, pix_sof, cfg_blur_en, cfg_sobel_en,
    input  pix_ready, blur_en, sobel_en, win_valid, col, row,
    input  res_sof, res_eol, frame_done, err_sof, busy
  );

  modport slave (
    input  pix_valid, pix_sof, cfg_blur_en, cfg_sobel_en,
    output pix_ready, blur_en, sobel_en, win_valid, col, row,
    output res_sof, res_eol, frame_done, err_sof, busy
  );
endinterface

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the 3x3 blur/Sobel chain: raster position tracking, window strobe,
// per-frame config latch, result-marker delay line and pipeline drain.
module filter_frame_ctrl #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input logic               clk,
  input logic               rst_n,
  filter_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

  localparam int unsigned CntW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                blur_q, blur_d;
  logic                sobel_q, sobel_d;
  logic                win_valid_q, win_valid_d;
  logic                win_sof_q, win_sof_d;
  logic                win_eol_q, win_eol_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [PIPE_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [PIPE_LAT-1:0] sr_sof_q, sr_sof_d;
  logic [PIPE_LAT-1:0] sr_eol_q, sr_eol_d;
  logic                pix_ready;
  logic                accept;
  logic                flush;

  assign pix_ready = (state_q == StIdle) || (state_q == StActive);
  assign accept    = bus.pix_valid & pix_ready;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    blur_d      = blur_q;
    sobel_d     = sobel_q;
    win_valid_d = 1'b0;
    win_sof_d   = 1'b0;
    win_eol_d   = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && bus.pix_sof) begin
          blur_d  = bus.cfg_blur_en;
          sobel_d = bus.cfg_sobel_en;
          col_d   = '0;
          row_d   = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        if (accept) begin
          if (bus.pix_sof) begin
            // Restart: the SOF pixel becomes (0,0) of a fresh frame.
            err_d   = 1'b1;
            flush   = 1'b1;
            blur_d  = bus.cfg_blur_en;
            sobel_d = bus.cfg_sobel_en;
            col_d   = '0;
            row_d   = '0;
          end else begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            win_valid_d = (row_d >= ROW_W'(2)) && (col_d >= COL_W'(2));
            win_sof_d   = (row_d == ROW_W'(2)) && (col_d == COL_W'(2));
            win_eol_d   = (col_d == COL_W'(IMG_WIDTH - 1));
            if ((row_d == ROW_W'(IMG_HEIGHT - 1)) && (col_d == COL_W'(IMG_WIDTH - 1))) begin
              state_d     = StDrain;
              drain_cnt_d = '0;
            end
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == CntW'(PIPE_LAT - 1)) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + CntW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Marker delay line; a mid-frame SOF drops everything still in flight.
  always_comb begin
    if (flush) begin
      sr_vld_d = '0;
      sr_sof_d = '0;
      sr_eol_d = '0;
    end else begin
      sr_vld_d = (sr_vld_q << 1) | PIPE_LAT'(win_valid_q);
      sr_sof_d = (sr_sof_q << 1) | PIPE_LAT'(win_valid_q & win_sof_q);
      sr_eol_d = (sr_eol_q << 1) | PIPE_LAT'(win_valid_q & win_eol_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      blur_q      <= 1'b0;
      sobel_q     <= 1'b0;
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_eol_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      sr_vld_q    <= '0;
      sr_sof_q    <= '0;
      sr_eol_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      blur_q      <= blur_d;
      sobel_q     <= sobel_d;
      win_valid_q <= win_valid_d;
      win_sof_q   <= win_sof_d;
      win_eol_q   <= win_eol_d;
      err_q       <= err_d;
      done_q      <= done_d;
      sr_vld_q    <= sr_vld_d;
      sr_sof_q    <= sr_sof_d;
      sr_eol_q    <= sr_eol_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.blur_en    = blur_q;
  assign bus.sobel_en   = sobel_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.res_sof    = sr_vld_q[PIPE_LAT-1] & sr_sof_q[PIPE_LAT-1];
  assign bus.res_eol    = sr_vld_q[PIPE_LAT-1] & sr_eol_q[PIPE_LAT-1];
  assign bus.frame_done = done_q;
  assign bus.err_sof    = err_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Bench for filter_frame_ctrl on a 4x3 image: directed scenarios plus random traffic,
// compared cycle by cycle against a pixel-index based reference model.
module tb_filter_frame_ctrl;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int P    = 2;
  localparam int CW   = 2;
  localparam int RW   = 2;
  localparam int NCYC = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  filter_frame_ctrl_if #(.COL_W(CW), .ROW_W(RW)) bus ();

  filter_frame_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIPE_LAT  (P),
    .COL_W     (CW),
    .ROW_W     (RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected one-cycle events, indexed by the cycle in which they are visible.
  bit exp_win [NCYC];
  bit exp_rsof[NCYC];
  bit exp_reol[NCYC];
  bit exp_done[NCYC];
  bit exp_err [NCYC];

  bit m_in_frame;
  int m_n;
  bit m_blur, m_sobel;
  int m_col, m_row;
  int m_block_until;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_in_frame    = 1'b0;
    m_n           = 0;
    m_blur        = 1'b0;
    m_sobel       = 1'b0;
    m_col         = 0;
    m_row         = 0;
    m_block_until = -1;
    for (int k = 0; k < NCYC; k++) begin
      exp_win[k]  = 1'b0;
      exp_rsof[k] = 1'b0;
      exp_reol[k] = 1'b0;
      exp_done[k] = 1'b0;
      exp_err[k]  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit blocked;
    blocked = (cyc <= m_block_until);
    chk("pix_ready",  bus.pix_ready,  !blocked);
    chk("busy",       bus.busy,       m_in_frame || blocked);
    chk("col",        bus.col,        m_col);
    chk("row",        bus.row,        m_row);
    chk("blur_en",    bus.blur_en,    m_blur);
    chk("sobel_en",   bus.sobel_en,   m_sobel);
    chk("win_valid",  bus.win_valid,  exp_win[cyc]);
    chk("res_sof",    bus.res_sof,    exp_rsof[cyc]);
    chk("res_eol",    bus.res_eol,    exp_reol[cyc]);
    chk("frame_done", bus.frame_done, exp_done[cyc]);
    chk("err_sof",    bus.err_sof,    exp_err[cyc]);
  endtask

  // Effect of one accepted pixel, visible from cycle cyc+1 onwards.
  task automatic model_accept(input bit s, input bit b, input bit so);
    int c;
    c = cyc + 1;
    if (!m_in_frame) begin
      if (!s) return;
      m_in_frame = 1'b1;
      m_blur     = b;
      m_sobel    = so;
      m_n        = 0;
    end else if (s) begin
      exp_err[c] = 1'b1;
      for (int k = c; k < NCYC; k++) begin
        exp_rsof[k] = 1'b0;
        exp_reol[k] = 1'b0;
      end
      m_blur  = b;
      m_sobel = so;
      m_n     = 0;
    end else begin
      m_n++;
    end
    m_col = m_n % W;
    m_row = m_n / W;
    if (m_row >= 2 && m_col >= 2) begin
      exp_win[c]    = 1'b1;
      exp_rsof[c+P] = (m_row == 2 && m_col == 2);
      exp_reol[c+P] = (m_col == W - 1);
    end
    if (m_n == W * H - 1) begin
      m_in_frame        = 1'b0;
      m_block_until     = c + P;
      exp_done[c+P+1]   = 1'b1;
    end
  endtask

  task automatic step(input bit v, input bit s, input bit b, input bit so);
    @(negedge clk);
    check_outputs();
    bus.pix_valid    = v;
    bus.pix_sof      = s;
    bus.cfg_blur_en  = b;
    bus.cfg_sobel_en = so;
    if (v && !(cyc <= m_block_until)) model_accept(s, b, so);
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  // mode 0: continuous, 1: valid toggles every cycle, 2: random gaps.
  // Non-SOF pixels carry inverted cfg to show it is ignored mid-frame.
  task automatic send_frame(input int mode, input bit b, input bit so);
    for (int i = 0; i < W * H; i++) begin
      if (mode == 1 && i > 0) step(1'b0, 1'b0, !b, !so);
      if (mode == 2) idle($urandom_range(0, 2));
      if (i == 0) step(1'b1, 1'b1, b, so);
      else        step(1'b1, 1'b0, !b, !so);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge clk);
    cyc++;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bus.pix_valid    = 1'b0;
    bus.pix_sof      = 1'b0;
    bus.cfg_blur_en  = 1'b0;
    bus.cfg_sobel_en = 1'b0;
    model_clear();
    do_reset();

    // Continuous frame, then let it drain fully.
    send_frame(0, 1'b1, 1'b0);
    idle(6);

    // Valid toggling every cycle.
    send_frame(1, 1'b0, 1'b1);
    idle(6);

    // Stray pixels in IDLE without SOF, then a normal frame.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(0, 1'b1, 1'b1);
    idle(6);

    // SOF injected at pixel 7, new frame completes.
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 1'b0, 1'b0);
    send_frame(0, 1'b1, 1'b0);
    idle(6);

    // Blur latched 1, cfg driven 0 mid-frame; the next frame latches 0.
    send_frame(0, 1'b1, 1'b1);
    idle(3);
    send_frame(2, 1'b0, 1'b0);
    idle(6);

    // Back-to-back: SOF driven on the frame_done cycle.
    send_frame(0, 1'b1, 1'b0);
    idle(3);
    send_frame(0, 1'b0, 1'b1);
    idle(6);

    // Reset during DRAIN: no frame_done may follow.
    send_frame(0, 1'b1, 1'b1);
    idle(1);
    do_reset();
    idle(6);

    // Random traffic with occasional SOF, including while not ready.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           1'($urandom), 1'($urandom));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
